// File: rtl/seq_muldiv_unit.sv
// Multi-cycle unsigned shift-add multiplier / restoring divider.
// Drives CCR flags with a single-cycle flag_en pulse.
module seq_muldiv_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             flag_en
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WB,
    S_DONE
  } state_t;

  state_t state, nxt;

  logic [CW-1:0]    cnt;
  logic             op_q;
  logic             dz_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
  logic           geq;
  logic           accept;

  assign accept = (state == S_IDLE) && start && !flush;

  // MUL: {hi,lo} starts as {0,b}; DIV: lo shifts dividend out, quotient in
  assign add_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : '0)};
  assign sh      = {hi_q, lo_q[WIDTH-1]};
  assign diff    = sh - {1'b0, m_q};
  assign geq     = (sh >= {1'b0, m_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start) nxt = (op && (b == '0)) ? S_WB : S_RUN;
      S_RUN:  if (cnt == CW'(WIDTH-1)) nxt = S_WB;
      S_WB:   nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (flush) nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= 1'b0;
      dz_q      <= 1'b0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_hi <= '0;
      result_lo <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= op;
      dz_q <= op && (b == '0);
      if (op) begin
        m_q <= b;
        if (b == '0) begin
          hi_q <= a;
          lo_q <= '1;
        end else begin
          hi_q <= '0;
          lo_q <= a;
        end
      end else begin
        m_q  <= a;
        hi_q <= '0;
        lo_q <= b;
      end
    end else if (state == S_RUN && !flush) begin
      cnt <= CW'(cnt + 1'b1);
      if (op_q) begin
        hi_q <= geq ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], geq};
      end else begin
        {hi_q, lo_q} <= {add_sum, lo_q[WIDTH-1:1]};
      end
    end else if (state == S_WB && !flush) begin
      result_hi <= hi_q;
      result_lo <= lo_q;
      if (op_q) begin
        Z <= (lo_q == '0);
        N <= lo_q[WIDTH-1];
        C <= 1'b0;
        V <= dz_q;
      end else begin
        Z <= ({hi_q, lo_q} == '0);
        N <= hi_q[WIDTH-1];
        C <= (hi_q != '0);
        V <= 1'b0;
      end
    end
  end

  assign busy    = (state == S_RUN) || (state == S_WB);
  assign done    = (state == S_DONE);
  assign flag_en = done;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed bench for seq_muldiv_unit (WIDTH=8).
// Vector table plus hand sequences for busy, flush and reset.
module tb_seq_muldiv_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, op, flush;
  logic [7:0] a, b;
  logic       busy, done, flag_en;
  logic [7:0] result_lo, result_hi;
  logic       Z, N, C, V;

  int n_cmp = 0;
  int n_bad = 0;

  seq_muldiv_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi),
    .Z(Z), .N(N), .C(C), .V(V), .flag_en(flag_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [3:0] zncv;
    int         lat;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic o, input logic [7:0] x,
                       input logic [7:0] y, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  initial begin
    int lat, nd;
    logic [7:0] lo_s;

    vt[0] = '{1'b0, 8'd12,  8'd10,  8'h00, 8'h78, 4'b0000, 9};
    vt[1] = '{1'b0, 8'hFF,  8'hFF,  8'hFE, 8'h01, 4'b0110, 9};
    vt[2] = '{1'b0, 8'h00,  8'h33,  8'h00, 8'h00, 4'b1000, 9};
    vt[3] = '{1'b1, 8'd100, 8'd7,   8'd2,  8'd14, 4'b0000, 9};
    vt[4] = '{1'b1, 8'h55,  8'h00,  8'h55, 8'hFF, 4'b0101, 1};
    vt[5] = '{1'b1, 8'd200, 8'd201, 8'd200, 8'd0, 4'b1000, 9};

    rst = 1'b1; start = 1'b0; op = 1'b0; flush = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", {result_hi, result_lo, Z, N, C, V}, '0);
    chk("rst_ctl", {busy, done, flag_en}, '0);
    rst = 1'b0;

    foreach (vt[i]) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, lat);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_hi", i), result_hi, vt[i].hi);
      chk($sformatf("v%0d_lo", i), result_lo, vt[i].lo);
      chk($sformatf("v%0d_zncv", i), {Z, N, C, V}, vt[i].zncv);
      chk($sformatf("v%0d_fen", i), flag_en, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {done, flag_en}, 2'b00);
    end

    // start while busy must be ignored
    @(negedge clk);
    op = 1'b1; a = 8'd100; b = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nd = 0; lo_s = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        chk("busy_mid", busy, 1'b1);
        op = 1'b0; a = 8'd3; b = 8'd3; start = 1'b1;
      end
      if (i == 4) start = 1'b0;
      if (done) begin
        nd++;
        lo_s = result_lo;
      end
    end
    chk("busy_ndone", nd, 1);
    chk("busy_lo", lo_s, 8'd14);

    // flush mid-multiply
    @(negedge clk);
    op = 1'b0; a = 8'd3; b = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy", busy, 1'b0);
    count_done(15, nd);
    chk("fl_ndone", nd, 0);
    chk("fl_hold", {result_hi, result_lo}, 16'h020E);
    do_op(1'b0, 8'd3, 8'd3, lat);
    chk("fl_lat", lat, 9);
    chk("fl_lo", result_lo, 8'd9);

    // flush beats start in IDLE
    @(negedge clk);
    op = 1'b0; a = 8'd5; b = 8'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("fs_busy", busy, 1'b0);
    count_done(12, nd);
    chk("fs_ndone", nd, 0);

    // async reset mid-divide
    @(negedge clk);
    op = 1'b1; a = 8'd200; b = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_out", {result_hi, result_lo, Z, N, C, V}, '0);
    chk("ar_ctl", {busy, done, flag_en}, '0);
    @(negedge clk);
    rst = 1'b0;
    count_done(15, nd);
    chk("ar_ndone", nd, 0);
    do_op(1'b1, 8'd9, 8'd3, lat);
    chk("ar_lat", lat, 9);
    chk("ar_res", {result_hi, result_lo}, 16'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
